// File: rtl/fp_pkg.sv
// Shared floating-point definitions: rounding-mode encodings, field widths and
// special-value classification helpers used across the FP units.
package fp_pkg;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  function automatic int unsigned exp_w(input int unsigned dlen);
    return (dlen == 64) ? 11 : 8;
  endfunction

  function automatic int unsigned mant_w(input int unsigned dlen);
    return (dlen == 64) ? 52 : 23;
  endfunction

  // Values are passed zero-extended to 64 bits so one helper serves both formats.
  function automatic logic [63:0] fp_exp(input logic [63:0] v, input int unsigned dlen);
    return (v >> mant_w(dlen)) & ((64'd1 << exp_w(dlen)) - 64'd1);
  endfunction

  function automatic logic [63:0] fp_mant(input logic [63:0] v, input int unsigned dlen);
    return v & ((64'd1 << mant_w(dlen)) - 64'd1);
  endfunction

  function automatic logic is_nan(input logic [63:0] v, input int unsigned dlen);
    return (fp_exp(v, dlen) == ((64'd1 << exp_w(dlen)) - 64'd1)) && (fp_mant(v, dlen) != '0);
  endfunction

  function automatic logic is_inf(input logic [63:0] v, input int unsigned dlen);
    return (fp_exp(v, dlen) == ((64'd1 << exp_w(dlen)) - 64'd1)) && (fp_mant(v, dlen) == '0);
  endfunction

  function automatic logic is_zero(input logic [63:0] v, input int unsigned dlen);
    return (fp_exp(v, dlen) == '0) && (fp_mant(v, dlen) == '0);
  endfunction

endpackage

// File: rtl/fp_round_decide.sv
// Combinational round-up decision from rounding mode, sign, LSB and G/R/S bits.
module fp_round_decide
  import fp_pkg::*;
(
  input  logic [1:0] mode_i,
  input  logic       sign_i,
  input  logic       lsb_i,
  input  logic       guard_i,
  input  logic       round_i,
  input  logic       sticky_i,
  output logic       inc_o,
  output logic       inexact_raw_o
);

  assign inexact_raw_o = guard_i | round_i | sticky_i;

  always_comb begin
    inc_o = 1'b0;
    case (mode_i)
      RM_RNE:  inc_o = guard_i & (round_i | sticky_i | lsb_i);
      RM_RTZ:  inc_o = 1'b0;
      RM_RUP:  inc_o = inexact_raw_o & ~sign_i;
      RM_RDN:  inc_o = inexact_raw_o & sign_i;
      default: inc_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_round.sv
// IEEE-754 rounding stage: applies the round-up decision to a truncated value,
// handles NaN/Inf/overflow, and registers the result with inexact/overflow flags.
module fp_round
  import fp_pkg::*;
#(
  parameter int unsigned D_Len = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [D_Len-1:0] in,
  input  logic [1:0]       round_mode,
  input  logic             guard_bit,
  input  logic             round_bit,
  input  logic             sticky_bit,
  output logic             out_valid,
  output logic [D_Len-1:0] r_result,
  output logic             inexact,
  output logic             overflow
);

  localparam int unsigned EW = exp_w(D_Len);
  localparam int unsigned MW = mant_w(D_Len);
  localparam logic [D_Len-1:0] QUIET_BIT = {{(D_Len-MW){1'b0}}, 1'b1, {(MW-1){1'b0}}};

  logic [63:0]      in_ext;
  logic             sign;
  logic             nan_in;
  logic             inf_in;
  logic             inc;
  logic             inexact_raw;
  logic [D_Len-2:0] mag_sum;
  logic             sum_ovf;

  logic             out_valid_q;
  logic [D_Len-1:0] r_result_q, r_result_d;
  logic             inexact_q, inexact_d;
  logic             overflow_q, overflow_d;

  assign in_ext = 64'(in);
  assign sign   = in[D_Len-1];
  assign nan_in = is_nan(in_ext, D_Len);
  assign inf_in = is_inf(in_ext, D_Len);

  fp_round_decide u_decide (
    .mode_i        (round_mode),
    .sign_i        (sign),
    .lsb_i         (in[0]),
    .guard_i       (guard_bit),
    .round_i       (round_bit),
    .sticky_i      (sticky_bit),
    .inc_o         (inc),
    .inexact_raw_o (inexact_raw)
  );

  // Single add over {exp, mant}: mantissa carries (incl. subnormal -> min normal)
  // ripple into the exponent without special casing.
  assign mag_sum = in[D_Len-2:0] + (D_Len-1)'(inc);
  assign sum_ovf = &mag_sum[D_Len-2 -: EW];

  always_comb begin
    r_result_d = {sign, mag_sum};
    inexact_d  = inexact_raw;
    overflow_d = 1'b0;
    if (nan_in) begin
      r_result_d = in | QUIET_BIT;
      inexact_d  = 1'b0;
    end else if (inf_in) begin
      r_result_d = in;
      inexact_d  = 1'b0;
    end else if (sum_ovf) begin
      r_result_d = {sign, {EW{1'b1}}, {MW{1'b0}}};
      inexact_d  = 1'b1;
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      r_result_q  <= '0;
      inexact_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        r_result_q <= r_result_d;
        inexact_q  <= inexact_d;
        overflow_q <= overflow_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign r_result  = r_result_q;
  assign inexact   = inexact_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fp_round.sv
// Directed self-checking bench for fp_round (binary32) with a result scoreboard.
module tb_fp_round;

  typedef struct {
    logic [31:0] res;
    logic        inex;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_d;
  logic [1:0]  mode;
  logic        g, r, s;
  logic        out_valid;
  logic [31:0] r_result;
  logic        inexact;
  logic        overflow;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_res;
  logic        last_inex;
  logic        last_ovf;

  fp_round #(.D_Len(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in         (in_d),
    .round_mode (mode),
    .guard_bit  (g),
    .round_bit  (r),
    .sticky_bit (s),
    .out_valid  (out_valid),
    .r_result   (r_result),
    .inexact    (inexact),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_out(input string tag);
    exp_t e;
    tests++;
    assert (out_valid === 1'b1) else begin
      fails++; $error("FAIL %s out_valid got %b want 1", tag, out_valid);
    end
    if (sb.size() == 0) begin
      tests++; fails++;
      $error("FAIL %s scoreboard empty, result %h", tag, r_result);
    end else begin
      e = sb.pop_front();
      tests++;
      assert (r_result === e.res) else begin
        fails++; $error("FAIL %s result got %h want %h", tag, r_result, e.res);
      end
      tests++;
      assert (inexact === e.inex) else begin
        fails++; $error("FAIL %s inexact got %b want %b", tag, inexact, e.inex);
      end
      tests++;
      assert (overflow === e.ovf) else begin
        fails++; $error("FAIL %s overflow got %b want %b", tag, overflow, e.ovf);
      end
      last_res = e.res; last_inex = e.inex; last_ovf = e.ovf;
    end
  endtask

  task automatic check_idle(input string tag, input logic [31:0] er, input logic ei, input logic eo);
    tests++;
    assert (out_valid === 1'b0) else begin
      fails++; $error("FAIL %s out_valid got %b want 0", tag, out_valid);
    end
    tests++;
    assert (r_result === er) else begin
      fails++; $error("FAIL %s result got %h want %h", tag, r_result, er);
    end
    tests++;
    assert (inexact === ei) else begin
      fails++; $error("FAIL %s inexact got %b want %b", tag, inexact, ei);
    end
    tests++;
    assert (overflow === eo) else begin
      fails++; $error("FAIL %s overflow got %b want %b", tag, overflow, eo);
    end
  endtask

  // Drive one valid operation, queue its expected output, check it after the edge.
  task automatic step(input string tag, input logic [31:0] v, input logic [1:0] m,
                      input logic [2:0] grs, input logic [31:0] er, input logic ei,
                      input logic eo);
    exp_t e;
    in_valid = 1'b1;
    in_d = v;
    mode = m;
    {g, r, s} = grs;
    e.res = er; e.inex = ei; e.ovf = eo;
    sb.push_back(e);
    @(posedge clk); #1;
    check_out(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_d = 32'h7F7F_FFFF; mode = 2'b00; {g, r, s} = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset", 32'h0, 1'b0, 1'b0);
    rst = 1'b0;

    step("rne_tie_even",  32'h4030_0000, 2'b00, 3'b100, 32'h4030_0000, 1'b1, 1'b0);
    step("rne_tie_odd",   32'h4030_0001, 2'b00, 3'b100, 32'h4030_0002, 1'b1, 1'b0);
    step("rne_above",     32'h4030_0000, 2'b00, 3'b110, 32'h4030_0001, 1'b1, 1'b0);
    step("rne_below",     32'h4030_0001, 2'b00, 3'b011, 32'h4030_0001, 1'b1, 1'b0);
    step("rtz_neg",       32'hC030_0000, 2'b01, 3'b100, 32'hC030_0000, 1'b1, 1'b0);
    step("rdn_neg",       32'hC030_0000, 2'b11, 3'b100, 32'hC030_0001, 1'b1, 1'b0);
    step("rup_pos",       32'h4030_0000, 2'b10, 3'b100, 32'h4030_0001, 1'b1, 1'b0);
    step("rup_neg",       32'hC030_0000, 2'b10, 3'b001, 32'hC030_0000, 1'b1, 1'b0);
    step("rdn_pos",       32'h4030_0000, 2'b11, 3'b010, 32'h4030_0000, 1'b1, 1'b0);
    step("exact",         32'h4030_0001, 2'b10, 3'b000, 32'h4030_0001, 1'b0, 1'b0);
    step("zero_exact",    32'h0000_0000, 2'b00, 3'b000, 32'h0000_0000, 1'b0, 1'b0);
    step("negzero_exact", 32'h8000_0000, 2'b10, 3'b000, 32'h8000_0000, 1'b0, 1'b0);
    step("negzero_rdn",   32'h8000_0000, 2'b11, 3'b001, 32'h8000_0001, 1'b1, 1'b0);
    step("inf",           32'h7F80_0000, 2'b10, 3'b100, 32'h7F80_0000, 1'b0, 1'b0);
    step("qnan",          32'h7FC0_0001, 2'b00, 3'b111, 32'h7FC0_0001, 1'b0, 1'b0);
    step("snan",          32'h7F80_0001, 2'b10, 3'b100, 32'h7FC0_0001, 1'b0, 1'b0);
    step("ovf_rne",       32'h7F7F_FFFF, 2'b00, 3'b111, 32'h7F80_0000, 1'b1, 1'b1);
    step("maxfin_rtz",    32'h7F7F_FFFF, 2'b01, 3'b111, 32'h7F7F_FFFF, 1'b1, 1'b0);
    step("ovf_neg_rdn",   32'hFF7F_FFFF, 2'b11, 3'b100, 32'hFF80_0000, 1'b1, 1'b1);
    step("sub_carry",     32'h007F_FFFF, 2'b10, 3'b100, 32'h0080_0000, 1'b1, 1'b0);
    step("minnorm_exact", 32'h0080_0000, 2'b00, 3'b000, 32'h0080_0000, 1'b0, 1'b0);

    // Idle cycle: out_valid drops while the last result and flags hold.
    step("pre_hold",      32'h7F7F_FFFF, 2'b00, 3'b100, 32'h7F80_0000, 1'b1, 1'b1);
    in_valid = 1'b0; in_d = 32'h1234_5678; {g, r, s} = 3'b000;
    @(posedge clk); #1;
    check_idle("hold", last_res, last_inex, last_ovf);

    // Reset asserted with a valid op at the same edge: the op must never appear.
    step("pre_reset",     32'h4030_0001, 2'b00, 3'b100, 32'h4030_0002, 1'b1, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_d = 32'h7F7F_FFFF; mode = 2'b00; {g, r, s} = 3'b111;
    @(posedge clk); #1;
    check_idle("mid_reset", 32'h0, 1'b0, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check_idle("dropped", 32'h0, 1'b0, 1'b0);

    step("recover",       32'h4030_0000, 2'b10, 3'b100, 32'h4030_0001, 1'b1, 1'b0);
    in_valid = 1'b0;

    tests++;
    assert (sb.size() == 0) else begin
      fails++; $error("FAIL sb_drain leftover %0d want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
